sprite_loader: RTL

//  Write-side counterpart of memorySprites: takes a byte stream (e.g. from a UART receiver)
//  and writes 32x32 RGB444 sprites into the sprite memory's write port, one element per frame.

---
 rtl/sprite_loader.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/sprite_loader.sv
// Byte-stream sprite loader: parses SYNC/element/pixel/checksum frames and
// drives the sprite memory write port one pixel at a time.
module sprite_loader #(
    parameter int          ELEMENT_W     = 3,
    parameter int          MAX_ELEMENT   = 7,
    parameter int          ADDR_W        = 10,
    parameter int          SPRITE_PIXELS = 1024,
    parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
    parameter logic [19:0] TIMEOUT       = 20'hFFFFF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_enable,
    input  logic [7:0]           byte_in,
    input  logic                 byte_valid,
    output logic                 byte_ready,
    output logic                 wr_en,
    output logic [ELEMENT_W-1:0] wr_element,
    output logic [ADDR_W-1:0]    wr_address,
    output logic [11:0]          wr_data,
    output logic                 busy,
    output logic                 load_done,
    output logic                 load_error,
    output logic [1:0]           err_code
);

    localparam logic [7:0]        MAX_IDX   = 8'(MAX_ELEMENT);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SPRITE_PIXELS - 1);
    localparam logic [19:0]       TMO_LAST  = TIMEOUT - 20'd1;

    typedef enum logic [2:0] {
        IDLE,
        ELEM,
        PIX_HI,
        PIX_LO,
        CHECK,
        RESULT
    } state_t;

    state_t                 state_q;
    logic [ADDR_W-1:0]      addr_q;
    logic [7:0]             csum_q;
    logic [3:0]             red_q;
    logic [19:0]            tmo_q;
    logic                   wr_en_q;
    logic [ELEMENT_W-1:0]   wr_element_q;
    logic [ADDR_W-1:0]      wr_address_q;
    logic [11:0]            wr_data_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   error_q;
    logic [1:0]             err_code_q;

    logic accept;
    logic in_frame;

    // Ready is held low while reset is asserted and during the one-cycle RESULT state.
    assign byte_ready = !reset && (state_q != RESULT);
    assign accept     = byte_valid && byte_ready;
    assign in_frame   = (state_q == ELEM) || (state_q == PIX_HI) ||
                        (state_q == PIX_LO) || (state_q == CHECK);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            csum_q       <= '0;
            red_q        <= '0;
            tmo_q        <= '0;
            wr_en_q      <= 1'b0;
            wr_element_q <= '0;
            wr_address_q <= '0;
            wr_data_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            err_code_q   <= 2'd0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;

            if (in_frame && !accept) begin
                tmo_q <= tmo_q + 20'd1;
            end else begin
                tmo_q <= '0;
            end

            case (state_q)
                IDLE: begin
                    if (accept && byte_in == SYNC_BYTE && load_enable) begin
                        state_q    <= ELEM;
                        busy_q     <= 1'b1;
                        err_code_q <= 2'd0;
                        csum_q     <= '0;
                    end
                end
                ELEM: begin
                    if (accept) begin
                        if (byte_in <= MAX_IDX) begin
                            wr_element_q <= byte_in[ELEMENT_W-1:0];
                            csum_q       <= csum_q ^ byte_in;
                            addr_q       <= '0;
                            state_q      <= PIX_HI;
                        end else begin
                            state_q    <= RESULT;
                            error_q    <= 1'b1;
                            err_code_q <= 2'd2;
                        end
                    end
                end
                PIX_HI: begin
                    if (accept) begin
                        red_q   <= byte_in[3:0];
                        csum_q  <= csum_q ^ byte_in;
                        state_q <= PIX_LO;
                    end
                end
                PIX_LO: begin
                    if (accept) begin
                        csum_q       <= csum_q ^ byte_in;
                        wr_en_q      <= 1'b1;
                        wr_address_q <= addr_q;
                        wr_data_q    <= {red_q, byte_in};
                        if (addr_q == LAST_ADDR) begin
                            state_q <= CHECK;
                        end else begin
                            addr_q  <= addr_q + 1'b1;
                            state_q <= PIX_HI;
                        end
                    end
                end
                CHECK: begin
                    if (accept) begin
                        state_q <= RESULT;
                        if (byte_in == csum_q) begin
                            done_q <= 1'b1;
                        end else begin
                            error_q    <= 1'b1;
                            err_code_q <= 2'd1;
                        end
                    end
                end
                RESULT: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

            // A stalled frame is abandoned; a write already registered still issues.
            if (in_frame && !accept && tmo_q == TMO_LAST) begin
                state_q    <= RESULT;
                error_q    <= 1'b1;
                err_code_q <= 2'd3;
            end
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_element = wr_element_q;
    assign wr_address = wr_address_q;
    assign wr_data    = wr_data_q;
    assign busy       = busy_q;
    assign load_done  = done_q;
    assign load_error = error_q;
    assign err_code   = err_code_q;

endmodule
